// File: rtl/sobel_edge_pipe.sv
// 3x3 Sobel gradient engine: three-stage fixed-latency pipeline with selectable
// magnitude approximation, runtime threshold, direction quantisation and per-frame edge count.
module sobel_edge_pipe #(
    parameter int DATA_W        = 8,
    parameter int DEF_THRESHOLD = 50,
    parameter int DEF_MODE      = 0,
    parameter int DEF_BINARY    = 0,
    parameter int CNT_W         = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] p11,
    input  logic [DATA_W-1:0] p12,
    input  logic [DATA_W-1:0] p13,
    input  logic [DATA_W-1:0] p21,
    input  logic [DATA_W-1:0] p22,
    input  logic [DATA_W-1:0] p23,
    input  logic [DATA_W-1:0] p31,
    input  logic [DATA_W-1:0] p32,
    input  logic [DATA_W-1:0] p33,
    input  logic [DATA_W-1:0] cfg_threshold,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_binary,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic [DATA_W-1:0] edge_out,
    output logic [1:0]        dir_out,
    output logic [CNT_W-1:0]  edge_count,
    output logic              count_valid
);

    localparam int SW = DATA_W + 2;   // column/row sum and |gradient| width
    localparam int MW = DATA_W + 3;   // magnitude width before saturation

    localparam logic [DATA_W-1:0] PIX_MAX = '1;
    localparam logic [DATA_W-1:0] RST_THR = DATA_W'(DEF_THRESHOLD);
    localparam logic [1:0]        RST_MODE = 2'(DEF_MODE);
    localparam logic              RST_BIN  = (DEF_BINARY != 0);

    // ------------------------------------------------------------------
    // Config shadowing. Each pixel carries its own config down the pipe so
    // that a new frame's sof cannot retune pixels of the previous frame
    // still in flight.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] act_threshold;
    logic [1:0]        act_mode;
    logic              act_binary;

    logic              load_cfg;
    logic [DATA_W-1:0] eff_threshold;
    logic [1:0]        eff_mode;
    logic              eff_binary;

    assign load_cfg      = in_valid && in_sof;
    assign eff_threshold = load_cfg ? cfg_threshold : act_threshold;
    assign eff_mode      = load_cfg ? cfg_mode      : act_mode;
    assign eff_binary    = load_cfg ? cfg_binary    : act_binary;

    // NOTE: every clocked register uses <= so all stages sample the values
    // from before the edge; blocking here would collapse the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_threshold <= RST_THR;
            act_mode      <= RST_MODE;
            act_binary    <= RST_BIN;
        end else if (load_cfg) begin
            act_threshold <= cfg_threshold;
            act_mode      <= cfg_mode;
            act_binary    <= cfg_binary;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: weighted column and row sums.
    // ------------------------------------------------------------------
    logic [SW-1:0]     sum_r, sum_l, sum_t, sum_b;
    logic              s1_valid, s1_sof, s1_eof;
    logic [SW-1:0]     s1_r, s1_l, s1_t, s1_b;
    logic [DATA_W-1:0] s1_thr;
    logic [1:0]        s1_mode;
    logic              s1_bin;

    assign sum_r = SW'(p13) + (SW'(p23) << 1) + SW'(p33);
    assign sum_l = SW'(p11) + (SW'(p21) << 1) + SW'(p31);
    assign sum_t = SW'(p11) + (SW'(p12) << 1) + SW'(p13);
    assign sum_b = SW'(p31) + (SW'(p32) << 1) + SW'(p33);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_r     <= '0;
            s1_l     <= '0;
            s1_t     <= '0;
            s1_b     <= '0;
            s1_thr   <= RST_THR;
            s1_mode  <= RST_MODE;
            s1_bin   <= RST_BIN;
        end else begin
            s1_valid <= in_valid;
            s1_sof   <= in_valid && in_sof;
            s1_eof   <= in_valid && in_eof;
            s1_r     <= sum_r;
            s1_l     <= sum_l;
            s1_t     <= sum_t;
            s1_b     <= sum_b;
            s1_thr   <= eff_threshold;
            s1_mode  <= eff_mode;
            s1_bin   <= eff_binary;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: gradient magnitudes and signs (gx = R-L, gy = T-B).
    // ------------------------------------------------------------------
    logic              s2_valid, s2_sof, s2_eof;
    logic [SW-1:0]     s2_ax, s2_ay;
    logic              s2_sx, s2_sy;
    logic [DATA_W-1:0] s2_thr;
    logic [1:0]        s2_mode;
    logic              s2_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_ax    <= '0;
            s2_ay    <= '0;
            s2_sx    <= 1'b0;
            s2_sy    <= 1'b0;
            s2_thr   <= RST_THR;
            s2_mode  <= RST_MODE;
            s2_bin   <= RST_BIN;
        end else begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eof   <= s1_eof;
            s2_ax    <= (s1_r >= s1_l) ? s1_r - s1_l : s1_l - s1_r;
            s2_ay    <= (s1_t >= s1_b) ? s1_t - s1_b : s1_b - s1_t;
            s2_sx    <= (s1_r < s1_l);
            s2_sy    <= (s1_t < s1_b);
            s2_thr   <= s1_thr;
            s2_mode  <= s1_mode;
            s2_bin   <= s1_bin;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, saturation, threshold and direction.
    // ------------------------------------------------------------------
    logic [SW-1:0]     g_max, g_min;
    logic [MW-1:0]     mag;
    logic [DATA_W-1:0] mag_sat;
    logic [DATA_W-1:0] edge_val;
    logic [1:0]        dir_val;

    // NOTE: each output of this block gets a default first, so no path
    // through the case/if chain can leave it unassigned and infer a latch.
    always_comb begin
        g_max    = (s2_ax >= s2_ay) ? s2_ax : s2_ay;
        g_min    = (s2_ax >= s2_ay) ? s2_ay : s2_ax;
        mag      = (MW'(s2_ax) + MW'(s2_ay)) >> 1;
        edge_val = '0;
        dir_val  = 2'd0;

        case (s2_mode)
            2'd1:    mag = MW'(g_max) + MW'(g_min >> 1);
            2'd2:    mag = MW'(g_max);
            default: mag = (MW'(s2_ax) + MW'(s2_ay)) >> 1;
        endcase

        mag_sat = (mag > MW'(PIX_MAX)) ? PIX_MAX : mag[DATA_W-1:0];

        if (mag_sat >= s2_thr)
            edge_val = s2_bin ? PIX_MAX : mag_sat;

        // A flat window (ax = ay = 0) falls into the first branch.
        if (s2_ay <= (s2_ax >> 1))
            dir_val = 2'd0;
        else if (s2_ax <= (s2_ay >> 1))
            dir_val = 2'd2;
        else if (s2_sx == s2_sy)
            dir_val = 2'd1;
        else
            dir_val = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            edge_out  <= '0;
            dir_out   <= 2'd0;
        end else begin
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_eof   <= s2_eof;
            if (s2_valid) begin
                edge_out <= edge_val;
                dir_out  <= dir_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-frame edge counter, reported one cycle after the eof pixel.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             edge_hit;

    assign edge_hit = (edge_out != '0);

    always_comb begin
        cnt_next = edge_cnt;
        if (out_sof)
            cnt_next = CNT_W'(edge_hit);
        else if (edge_hit && (edge_cnt != '1))
            cnt_next = edge_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt    <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (out_valid) begin
                if (out_eof) begin
                    edge_count  <= cnt_next;
                    count_valid <= 1'b1;
                    edge_cnt    <= '0;
                end else begin
                    edge_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Directed self-checking bench for sobel_edge_pipe (DATA_W=8, default config).
module tb_sobel_edge_pipe;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 20;

    localparam int WIN_FLAT   = 0;   // all nine pixels = v
    localparam int WIN_RCOL   = 1;   // p13 = p23 = p33 = v, rest 0
    localparam int WIN_CORNER = 2;   // p33 = v, rest 0

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_sof, in_eof;
    logic [DATA_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [DATA_W-1:0] cfg_threshold;
    logic [1:0]        cfg_mode;
    logic              cfg_binary;
    logic              out_valid, out_sof, out_eof;
    logic [DATA_W-1:0] edge_out;
    logic [1:0]        dir_out;
    logic [CNT_W-1:0]  edge_count;
    logic              count_valid;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] edge_q[$];
    logic [1:0]        dir_q[$];
    logic [CNT_W-1:0]  cnt_q[$];

    sobel_edge_pipe #(
        .DATA_W(DATA_W), .DEF_THRESHOLD(50), .DEF_MODE(0), .DEF_BINARY(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .p11(p11), .p12(p12), .p13(p13),
        .p21(p21), .p22(p22), .p23(p23),
        .p31(p31), .p32(p32), .p33(p33),
        .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode), .cfg_binary(cfg_binary),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .edge_out(edge_out), .dir_out(dir_out),
        .edge_count(edge_count), .count_valid(count_valid)
    );

    always #5 clk = ~clk;

    // Capture results away from the active edge.
    always @(negedge clk) begin
        if (out_valid) begin
            edge_q.push_back(edge_out);
            dir_q.push_back(dir_out);
        end
        if (count_valid)
            cnt_q.push_back(edge_count);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_win(input int kind, input logic [DATA_W-1:0] v);
        {p11, p12, p13, p21, p22, p23, p31, p32, p33} = '0;
        case (kind)
            WIN_FLAT:  {p11, p12, p13, p21, p22, p23, p31, p32, p33} = {9{v}};
            WIN_RCOL:  {p13, p23, p33} = {3{v}};
            default:   p33 = v;
        endcase
    endtask

    task automatic push_pix(input int kind, input logic [DATA_W-1:0] v, input logic sof, input logic eof);
        set_win(kind, v);
        in_valid = 1'b1;
        in_sof   = sof;
        in_eof   = eof;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic set_cfg(input logic [DATA_W-1:0] thr, input logic [1:0] mode, input logic bin);
        cfg_threshold = thr;
        cfg_mode      = mode;
        cfg_binary    = bin;
    endtask

    task automatic clear_q();
        edge_q.delete();
        dir_q.delete();
        cnt_q.delete();
    endtask

    function automatic logic [DATA_W-1:0] pop_edge();
        if (edge_q.size() == 0) return 'x;
        return edge_q.pop_front();
    endfunction

    function automatic logic [1:0] pop_dir();
        if (dir_q.size() == 0) return 'x;
        return dir_q.pop_front();
    endfunction

    function automatic logic [CNT_W-1:0] pop_cnt();
        if (cnt_q.size() == 0) return 'x;
        return cnt_q.pop_front();
    endfunction

    // 10-pixel frame pattern for test 5: 1 = edge window
    logic [9:0] frame5_edges = 10'b01_0011_0010;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        set_win(WIN_FLAT, 8'd0);
        set_cfg(8'd0, 2'd0, 1'b0);
        idle(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_edge_out", edge_out, 0);
        check("rst_dir_out", dir_out, 0);
        check("rst_edge_count", edge_count, 0);
        check("rst_count_valid", count_valid, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: flat window, exact 3-cycle latency, default config
        clear_q();
        push_pix(WIN_FLAT, 8'd100, 1'b0, 1'b0);
        check("t1_lat1", out_valid, 0);
        tick();
        check("t1_lat2", out_valid, 0);
        tick();
        check("t1_lat3", out_valid, 1);
        check("t1_edge", edge_out, 0);
        check("t1_dir", dir_out, 0);
        tick();
        check("t1_lat4", out_valid, 0);
        idle(3);

        // 2: strong vertical edge saturates to 255
        clear_q();
        set_cfg(8'd50, 2'd0, 1'b0);
        push_pix(WIN_RCOL, 8'd255, 1'b1, 1'b1);
        idle(6);
        check("t2_edge", pop_edge(), 255);
        check("t2_dir", pop_dir(), 0);
        check("t2_count", pop_cnt(), 1);

        // 3: three single-pixel frames back to back, modes 0/1/2
        clear_q();
        for (int m = 0; m < 3; m++) begin
            set_cfg(8'd100, 2'(m), 1'b0);
            push_pix(WIN_CORNER, 8'd80, 1'b1, 1'b1);
        end
        idle(6);
        check("t3_m0_edge", pop_edge(), 0);
        check("t3_m0_dir", pop_dir(), 3);
        check("t3_m1_edge", pop_edge(), 120);
        check("t3_m1_dir", pop_dir(), 3);
        check("t3_m2_edge", pop_edge(), 0);
        check("t3_m2_dir", pop_dir(), 3);
        check("t3_count0", pop_cnt(), 0);
        check("t3_count1", pop_cnt(), 1);
        check("t3_count2", pop_cnt(), 0);

        // 4: binary output, threshold boundary, mid-frame change ignored
        clear_q();
        set_cfg(8'd80, 2'd2, 1'b1);
        push_pix(WIN_CORNER, 8'd80, 1'b1, 1'b0);
        cfg_threshold = 8'd81;
        push_pix(WIN_CORNER, 8'd80, 1'b0, 1'b1);
        push_pix(WIN_CORNER, 8'd80, 1'b1, 1'b1);
        idle(6);
        check("t4_thr80_edge", pop_edge(), 255);
        check("t4_midframe_edge", pop_edge(), 255);
        check("t4_thr81_edge", pop_edge(), 0);
        check("t4_count_a", pop_cnt(), 2);
        check("t4_count_b", pop_cnt(), 0);

        // 5: 10-pixel frame with gaps, then an immediate 3-pixel frame
        clear_q();
        set_cfg(8'd50, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_pix(frame5_edges[i] ? WIN_RCOL : WIN_FLAT,
                     frame5_edges[i] ? 8'd255 : 8'd100, i == 0, i == 9);
            if (i != 9) idle(int'($urandom_range(0, 2)));
        end
        push_pix(WIN_FLAT, 8'd100, 1'b1, 1'b0);
        push_pix(WIN_RCOL, 8'd255, 1'b0, 1'b0);
        push_pix(WIN_FLAT, 8'd100, 1'b0, 1'b1);
        idle(6);
        check("t5_pixels", edge_q.size(), 13);
        check("t5_pulses", cnt_q.size(), 2);
        check("t5_count_a", pop_cnt(), 4);
        check("t5_count_b", pop_cnt(), 1);

        // 6: reset with two pixels in flight
        clear_q();
        set_cfg(8'd200, 2'd2, 1'b1);
        push_pix(WIN_RCOL, 8'd255, 1'b1, 1'b0);
        push_pix(WIN_RCOL, 8'd255, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_edge", edge_out, 0);
        check("t6_rst_dir", dir_out, 0);
        idle(6);
        check("t6_no_output", edge_q.size(), 0);
        check("t6_no_count", cnt_q.size(), 0);
        check("t6_edge_count", edge_count, 0);
        push_pix(WIN_CORNER, 8'd80, 1'b0, 1'b0);
        idle(4);
        check("t6_default_cfg_edge", pop_edge(), 80);
        check("t6_default_cfg_dir", pop_dir(), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
